// File: rtl/dart_score_display.sv
// rtl/dart_score_display.sv - multiplexed 4-digit seven-segment driver for the dart game core
module dart_score_display #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] player_id,
    input  logic [4:0] score_display,
    input  logic [4:0] final_score,
    input  logic [4:0] winner,
    input  logic       page_toggle,
    input  logic       game_done,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int RC_W = $clog2(REFRESH_DIV);
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [3:0] D_P     = 4'd10;
    localparam logic [3:0] D_DASH  = 4'd11;
    localparam logic [3:0] D_BLANK = 4'd15;

    typedef enum logic {LIVE, RESULT} page_t;

    page_t            page, page_next, snap_page;
    logic [RC_W-1:0]  rc;
    logic [1:0]       si;
    logic [FC_W-1:0]  fc;
    logic             blink;
    logic             primed;
    logic             tick, frame_end, load;
    logic [2:0]       snap_player;
    logic [4:0]       snap_score, snap_final, snap_winner;
    logic [3:0]       dig;

    function automatic logic [3:0] tens_of(input logic [4:0] v);
        if (v >= 5'd30)      return 4'd3;
        else if (v >= 5'd20) return 4'd2;
        else if (v >= 5'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [4:0] v);
        logic [4:0] sub;
        case (tens_of(v))
            4'd3:    sub = 5'd30;
            4'd2:    sub = 5'd20;
            4'd1:    sub = 5'd10;
            default: sub = 5'd0;
        endcase
        return 4'(v - sub);
    endfunction

    function automatic logic [3:0] tens_digit(input logic [4:0] v);
        return (tens_of(v) == 4'd0) ? D_BLANK : tens_of(v);
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            D_P:     return 7'b0001100;
            D_DASH:  return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    assign tick      = (rc == RC_W'(REFRESH_DIV - 1));
    assign frame_end = tick && (si == 2'd3);
    // The very first clock after reset also loads so the display never shows stale data for a frame.
    assign load      = frame_end || !primed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) page <= LIVE;
        else       page <= page_next;
    end

    always_comb begin
        page_next = page;
        case (page)
            LIVE:    if (page_toggle || game_done)  page_next = RESULT;
            RESULT:  if (page_toggle && !game_done) page_next = LIVE;
            default: page_next = LIVE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc     <= '0;
            si     <= 2'd0;
            fc     <= '0;
            blink  <= 1'b0;
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
            rc     <= tick ? '0 : rc + 1'b1;
            if (tick) si <= si + 2'd1;
            if (frame_end) begin
                if (fc == FC_W'(BLINK_FRAMES - 1)) begin
                    fc    <= '0;
                    blink <= ~blink;
                end else begin
                    fc <= fc + 1'b1;
                end
            end
        end
    end

    // Page is taken from the next-state so a toggle on a boundary lands in that snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_page   <= LIVE;
            snap_player <= '0;
            snap_score  <= '0;
            snap_final  <= '0;
            snap_winner <= '0;
        end else if (load) begin
            snap_page   <= page_next;
            snap_player <= player_id;
            snap_score  <= score_display;
            snap_final  <= final_score;
            snap_winner <= winner;
        end
    end

    always_comb begin
        dig = D_BLANK;
        if (snap_page == LIVE) begin
            case (si)
                2'd3:    dig = D_P;
                2'd2:    dig = {1'b0, snap_player};
                2'd1:    dig = tens_digit(snap_score);
                default: dig = ones_of(snap_score);
            endcase
        end else begin
            case (si)
                2'd3:    dig = blink ? D_BLANK :
                               (snap_winner <= 5'd9) ? snap_winner[3:0] : D_DASH;
                2'd2:    dig = D_DASH;
                2'd1:    dig = tens_digit(snap_final);
                default: dig = ones_of(snap_final);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << si);
            seg <= glyph(dig);
            dp  <= 1'b1;
        end
    end
endmodule

// File: doc/dart_score_display.md
# dart_score_display

Multiplexed 4-digit seven-segment driver that sits directly downstream of the digital dart game core. It consumes the game's `player_id`, `score_display`, `final_score` and `winner` outputs and scans them onto a common-anode display. It freezes a tear-free snapshot once per scan frame and switches between a live page and a result page under a small page FSM. On the result page the winner digit blinks.

## Interface
- `REFRESH_DIV`, default 1000: clocks each digit stays lit; legal range ≥ 2.
- `BLINK_FRAMES`, default 64: complete frames per blink half-period; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `player_id`  in  3  current player, from game core
- `score_display`  in  5  current player's score
- `final_score`  in  5  highest score
- `winner`  in  5  winning player number
- `page_toggle`  in  1  one-cycle pulse, already synchronized; requests a page swap
- `game_done`  in  1  level; forces the result page while high
- `an`  out  4  digit enables, active-low; `an[0]` is the rightmost digit
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low
- `dp`  out  1  decimal point, active-low; held at 1

## Operation
- Refresh counter `rc` counts 0..REFRESH_DIV-1 and wraps.
  - On wrap (tick), scan index `si` advances 0→1→2→3→0.
  - A frame boundary is a tick where `si` goes 3→0.
- Snapshot register holds: `player_id`, `score_display`, `final_score`, `winner`, and the page.
  - It loads on every frame boundary.
  - It also loads once on the first clock after reset release (primed flag).
  - Displayed data changes only at these points.
- Page FSM, states LIVE and RESULT:
  - LIVE→RESULT on a `page_toggle` pulse, or when `game_done`=1.
  - RESULT→LIVE on a `page_toggle` pulse, only while `game_done`=0.
  - `page_toggle` is ignored while `game_done`=1.
  - When `game_done` falls, the FSM stays in RESULT.
  - A pending page change is visible from the next snapshot load.
- Frame counter counts frame boundaries 0..BLINK_FRAMES-1. On its wrap, `blink` toggles.
- Score conversion for a 5-bit value v:
  - tens = 3 if v≥30, 2 if v≥20, 1 if v≥10, else 0.
  - ones = v − 10·tens.
  - tens is shown blank when 0.
- LIVE page digits:
  - d3 = 'P'
  - d2 = `player_id` (0–7)
  - d1 = score tens
  - d0 = score ones
- RESULT page digits:
  - d3 = `winner` if 0–9, otherwise dash. d3 is blank while `blink`=1.
  - d2 = dash
  - d1 = `final_score` tens
  - d0 = `final_score` ones
- Glyph codes `seg` (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - P=0001100, dash=0111111, blank=1111111
- `an` has exactly one bit low (bit `si`) after the first clock. `seg` is the glyph for digit `si`.

## Timing
- Reset (asynchronous, immediate, including mid-frame) sets:
  - `an`=1111, `seg`=1111111, `dp`=1
  - `rc`=0, `si`=0, frame counter=0, `blink`=0
  - page=LIVE, snapshot=0, primed=0
- `an`, `seg` and `dp` are registered. They reflect the current `si` and snapshot with a one-clock latency.
- First clock after reset release: the snapshot loads and `an` becomes 1110. The outputs then show the snapshotted data from the following clock.
- Each digit is held for exactly REFRESH_DIV clocks. A frame is 4·REFRESH_DIV clocks.
- A `page_toggle` on the same clock as a frame boundary takes effect in the snapshot loaded at that boundary.
- A `page_toggle` coinciding with a `game_done` rise leaves the FSM in RESULT.
- Input changes within a frame are invisible until the next frame boundary.
- Blink half-period is BLINK_FRAMES·4·REFRESH_DIV clocks.

## Test plan
Unless noted, use REFRESH_DIV=4 and BLINK_FRAMES=2.
- **Reset:** reset held → `an`=1111, `seg`=1111111, `dp`=1. After release, `an` sequences 1110,1101,1011,0111 with 4 clocks each, repeating.
- **LIVE page:** `player_id`=2, `score_display`=23 → d3=0001100, d2=0100100, d1=0100100, d0=0110000. With `score_display`=7, d1=blank and d0=1111000.
- **Tear-free update:** change `score_display` from 23 to 31 mid-frame → displayed value stays 23 until the next `si` 3→0, then shows d1=0110000, d0=1111001.
- **Page FSM:** `page_toggle` pulse → RESULT with `winner`=3, `final_score`=30: d3 alternates 0110000/blank every 8 clocks·4 (32 clocks), d2=0111111, d1=0110000, d0=1000000. A second pulse returns to LIVE.
- **game_done override:** with `game_done`=1, pulse `page_toggle` → stays RESULT. `game_done`→0 → still RESULT. Next pulse → LIVE. Also check `winner`=12 → d3 shows dash.
- **Reset mid-operation:** assert reset during d2 of a RESULT frame → outputs go to reset values in the same cycle. After release, page=LIVE and scanning restarts at d0.
